// File: rtl/memory_map_bus_if.sv
// CPU-side request/response bus of the memory map: one access per cycle,
// read data returned one cycle after acceptance.
interface memory_map_bus_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, address, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, address, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/memory_map_bus.sv
// Word-addressed memory map: general RAM, screen memory with a display scan port, keyboard
// register at RAM_DEPTH+SCREEN_DEPTH. Define KBD_FIFO_EN for a KBD_DEPTH-entry key queue.
module memory_map_bus #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int RAM_DEPTH    = 16384,
  parameter int SCREEN_DEPTH = 8192,
  parameter int KBD_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  memory_map_bus_if.slave                 bus,
  input  logic [$clog2(SCREEN_DEPTH)-1:0] scan_addr,
  output logic [DATA_W-1:0]               scan_data,
  input  logic [DATA_W-1:0]               kbd_code,
  input  logic                            kbd_strobe,
  output logic                            kbd_overflow
);

  localparam int RAM_AW   = $clog2(RAM_DEPTH);
  localparam int SCR_AW   = $clog2(SCREEN_DEPTH);
  localparam int KBD_ADDR = RAM_DEPTH + SCREEN_DEPTH;

  typedef enum logic {CLEAR, RUN} state_t;
  typedef enum logic [1:0] {SRC_RAM, SRC_SCR, SRC_KBD, SRC_NONE} src_t;

  state_t            state_reg, state_next;
  logic [SCR_AW-1:0] clear_cnt_reg, clear_cnt_next;
  logic              ready;
  logic              clear_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= CLEAR;
      clear_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clear_cnt_reg <= clear_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clear_cnt_next = clear_cnt_reg;
    if (state_reg == CLEAR) begin
      clear_cnt_next = clear_cnt_reg + 1'b1;
      if (clear_cnt_reg == SCR_AW'(SCREEN_DEPTH - 1))
        state_next = RUN;
    end
  end

  always_comb begin
    ready    = (state_reg == RUN);
    clear_we = (state_reg == CLEAR);
  end

  assign bus.ready = ready;

  // Address decode
  logic [31:0]       addr_ext;
  logic              is_ram, is_scr, is_kbd;
  logic              acc, rd_acc, wr_acc;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;

  assign addr_ext = 32'(bus.address);
  assign is_ram   = addr_ext < 32'(RAM_DEPTH);
  assign is_scr   = !is_ram && (addr_ext < 32'(KBD_ADDR));
  assign is_kbd   = addr_ext == 32'(KBD_ADDR);
  assign acc      = bus.req & ready;
  assign rd_acc   = acc & ~bus.we;
  assign wr_acc   = acc & bus.we;
  assign ram_idx  = RAM_AW'(bus.address);
  assign scr_idx  = SCR_AW'(addr_ext - 32'(RAM_DEPTH));

  // Screen write port is shared between the power-up clear and the CPU
  logic              scr_we;
  logic [SCR_AW-1:0] scr_waddr;
  logic [DATA_W-1:0] scr_wdata;

  assign scr_we    = clear_we | (wr_acc & is_scr);
  assign scr_waddr = clear_we ? clear_cnt_reg : scr_idx;
  assign scr_wdata = clear_we ? '0 : bus.wdata;

  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [DATA_W-1:0] screen [SCREEN_DEPTH];
  logic [DATA_W-1:0] ram_q_reg, scr_q_reg, scan_q_reg;

  always_ff @(posedge clk) begin
    if (wr_acc && is_ram)
      ram[ram_idx] <= bus.wdata;
    ram_q_reg <= ram[ram_idx];
  end

  // Read-before-write: a scan of the word being written this cycle sees the old value
  always_ff @(posedge clk) begin
    if (scr_we)
      screen[scr_waddr] <= scr_wdata;
    scr_q_reg  <= screen[scr_idx];
    scan_q_reg <= screen[scan_addr];
  end

  // Response tracking; the raw memory outputs are masked so rdata/scan_data are 0 after reset
  logic              rvalid_reg, err_reg, scan_valid_reg;
  src_t              src_reg;
  logic [DATA_W-1:0] kbd_q_reg;
  logic              kbd_overflow_reg;
  logic              kbd_pop;
  logic [DATA_W-1:0] rdata_mux;

  assign kbd_pop = rd_acc & is_kbd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_reg     <= 1'b0;
      err_reg        <= 1'b0;
      src_reg        <= SRC_NONE;
      scan_valid_reg <= 1'b0;
    end else begin
      rvalid_reg     <= rd_acc;
      err_reg        <= acc & ~is_ram & ~is_scr & ~(is_kbd & ~bus.we);
      scan_valid_reg <= 1'b1;
      if (rd_acc) begin
        if (is_ram)      src_reg <= SRC_RAM;
        else if (is_scr) src_reg <= SRC_SCR;
        else if (is_kbd) src_reg <= SRC_KBD;
        else             src_reg <= SRC_NONE;
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    if (rvalid_reg) begin
      case (src_reg)
        SRC_RAM: rdata_mux = ram_q_reg;
        SRC_SCR: rdata_mux = scr_q_reg;
        SRC_KBD: rdata_mux = kbd_q_reg;
        default: rdata_mux = '0;
      endcase
    end
  end

  assign bus.rvalid   = rvalid_reg;
  assign bus.rdata    = rdata_mux;
  assign bus.err      = err_reg;
  assign scan_data    = scan_valid_reg ? scan_q_reg : '0;
  assign kbd_overflow = kbd_overflow_reg;

`ifdef KBD_FIFO_EN
  localparam int KBD_AW = $clog2(KBD_DEPTH);

  logic [DATA_W-1:0] kbd_mem [KBD_DEPTH];
  logic [KBD_AW-1:0] kbd_wr_ptr_reg, kbd_rd_ptr_reg;
  logic [KBD_AW:0]   kbd_count_reg;
  logic              kbd_empty, kbd_full, do_push, do_pop, drop;

  assign kbd_empty = (kbd_count_reg == '0);
  assign kbd_full  = (kbd_count_reg == (KBD_AW+1)'(KBD_DEPTH));
  assign do_pop    = kbd_pop & ~kbd_empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts the key
  assign do_push   = kbd_strobe & (~kbd_full | do_pop);
  assign drop      = kbd_strobe & ~do_push;

  always_ff @(posedge clk) begin
    if (do_push)
      kbd_mem[kbd_wr_ptr_reg] <= kbd_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_wr_ptr_reg   <= '0;
      kbd_rd_ptr_reg   <= '0;
      kbd_count_reg    <= '0;
      kbd_q_reg        <= '0;
      kbd_overflow_reg <= 1'b0;
    end else begin
      if (do_push)
        kbd_wr_ptr_reg <= kbd_wr_ptr_reg + 1'b1;
      if (do_pop)
        kbd_rd_ptr_reg <= kbd_rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)
        kbd_count_reg <= kbd_count_reg + 1'b1;
      else if (do_pop && !do_push)
        kbd_count_reg <= kbd_count_reg - 1'b1;
      if (kbd_pop)
        kbd_q_reg <= kbd_empty ? '0 : kbd_mem[kbd_rd_ptr_reg];
      if (drop)
        kbd_overflow_reg <= 1'b1;
      else if (kbd_pop)
        kbd_overflow_reg <= 1'b0;
    end
  end
`else
  logic [DATA_W-1:0] kbd_hold_reg;
  logic              kbd_full_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_hold_reg     <= '0;
      kbd_full_reg     <= 1'b0;
      kbd_q_reg        <= '0;
      kbd_overflow_reg <= 1'b0;
    end else begin
      if (kbd_pop)
        kbd_q_reg <= kbd_hold_reg;
      if (kbd_strobe) begin
        kbd_hold_reg <= kbd_code;
        kbd_full_reg <= 1'b1;
      end else if (kbd_pop) begin
        kbd_hold_reg <= '0;
        kbd_full_reg <= 1'b0;
      end
      // Only an unread key being replaced counts as lost
      if (kbd_strobe && kbd_full_reg && !kbd_pop)
        kbd_overflow_reg <= 1'b1;
      else if (kbd_pop)
        kbd_overflow_reg <= 1'b0;
    end
  end
`endif

endmodule
